// File: rtl/regfile_fifo_ctrl.sv
// regfile_fifo_ctrl
// Flow-control stage in front of the one-hot read/write address ring counters
// of the register-file FIFO. Qualifies producer/consumer requests into
// WriteEn/ReadEn strobes and keeps shadow binary pointers, occupancy,
// registered status flags and a read-data-valid strobe.
// Optional feature macro: FIFO_ERR_FLAGS_EN adds sticky ovf_err/udf_err outputs.
module regfile_fifo_ctrl #(
  parameter int DEPTH    = 15,
  parameter int AF_LEVEL = 13,
  parameter int AE_LEVEL = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_req,
  input  logic       rd_req,
  output logic       WriteEn,
  output logic       ReadEn,
  output logic       rd_valid,
  output logic [3:0] wr_ptr,
  output logic [3:0] rd_ptr,
  output logic [3:0] level,
  output logic       full,
  output logic       empty,
  output logic       almost_full,
  output logic       almost_empty
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic       ovf_err,
  output logic       udf_err
`endif
);

  localparam logic [3:0] depthW   = 4'(DEPTH);
  localparam logic [3:0] lastIdx  = 4'(DEPTH - 1);
  localparam logic [3:0] afLevelW = 4'(AF_LEVEL);
  localparam logic [3:0] aeLevelW = 4'(AE_LEVEL);

  logic [3:0] levelNext;
  logic [3:0] wrPtrNext;
  logic [3:0] rdPtrNext;

  // Strobes are gated by the registered flags, so a request against a full or
  // empty FIFO is dropped even when the opposite side is accepted.
  assign WriteEn = wr_req & ~full;
  assign ReadEn  = rd_req & ~empty;

  // Next occupancy and next pointer values, wrapping at the ring length.
  always_comb begin
    levelNext = level;
    wrPtrNext = wr_ptr;
    rdPtrNext = rd_ptr;
    case ({WriteEn, ReadEn})
      2'b10:   levelNext = level + 4'd1;
      2'b01:   levelNext = level - 4'd1;
      default: levelNext = level;
    endcase
    if (WriteEn) begin
      wrPtrNext = (wr_ptr == lastIdx) ? 4'd0 : wr_ptr + 4'd1;
    end else begin
      wrPtrNext = wr_ptr;
    end
    if (ReadEn) begin
      rdPtrNext = (rd_ptr == lastIdx) ? 4'd0 : rd_ptr + 4'd1;
    end else begin
      rdPtrNext = rd_ptr;
    end
  end

  // Pointer, occupancy, flag and read-valid registers; flags come from the
  // next level so they are aligned with the level they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= 4'd0;
      rd_ptr       <= 4'd0;
      level        <= 4'd0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      rd_valid     <= 1'b0;
    end else begin
      wr_ptr       <= wrPtrNext;
      rd_ptr       <= rdPtrNext;
      level        <= levelNext;
      full         <= (levelNext == depthW);
      empty        <= (levelNext == 4'd0);
      almost_full  <= (levelNext >= afLevelW);
      almost_empty <= (levelNext <= aeLevelW);
      rd_valid     <= ReadEn;
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  // Sticky overflow/underflow flags, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_err <= 1'b0;
      udf_err <= 1'b0;
    end else begin
      ovf_err <= ovf_err | (wr_req & full);
      udf_err <= udf_err | (rd_req & empty);
    end
  end
`endif

endmodule

// File: tb/tb_regfile_fifo_ctrl.sv
// Self-checking bench for regfile_fifo_ctrl: scoreboard of expected
// post-edge state plus a table of constant vectors and hand-written corners.
module tb_regfile_fifo_ctrl;

  localparam int DEPTH = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_req = 1'b0;
  logic       rd_req = 1'b0;
  logic       WriteEn, ReadEn, rd_valid;
  logic [3:0] wr_ptr, rd_ptr, level;
  logic       full, empty, almost_full, almost_empty;
`ifdef FIFO_ERR_FLAGS_EN
  logic       ovf_err, udf_err;
`endif

  regfile_fifo_ctrl #(.DEPTH(15), .AF_LEVEL(13), .AE_LEVEL(2)) dut (
    .clk(clk), .rst_n(rst_n), .wr_req(wr_req), .rd_req(rd_req),
    .WriteEn(WriteEn), .ReadEn(ReadEn), .rd_valid(rd_valid),
    .wr_ptr(wr_ptr), .rd_ptr(rd_ptr), .level(level),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty)
`ifdef FIFO_ERR_FLAGS_EN
    , .ovf_err(ovf_err), .udf_err(udf_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int lvl; int wp; int rp; int vld; int ovf; int udf;
  } exp_t;

  typedef struct {
    bit wr; bit rd; bit expWe; bit expRe; int expLevel;
  } vec_t;

  exp_t expQ[$];
  int passCount = 0;
  int totalCount = 0;

  // reference model state
  int mLevel = 0, mWr = 0, mRd = 0, mValid = 0, mOvf = 0, mUdf = 0;
  bit lastWe, lastRe;

  task automatic check(input string name, input int act, input int exp);
    totalCount++;
    if (act == exp) passCount++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic modelReset();
    mLevel = 0; mWr = 0; mRd = 0; mValid = 0; mOvf = 0; mUdf = 0;
    expQ.delete();
  endtask

  // compare all registered outputs against one expected record
  task automatic compareState(input exp_t e);
    check("level", int'(level), e.lvl);
    check("wr_ptr", int'(wr_ptr), e.wp);
    check("rd_ptr", int'(rd_ptr), e.rp);
    check("full", int'(full), int'(e.lvl == DEPTH));
    check("empty", int'(empty), int'(e.lvl == 0));
    check("almost_full", int'(almost_full), int'(e.lvl >= 13));
    check("almost_empty", int'(almost_empty), int'(e.lvl <= 2));
    check("rd_valid", int'(rd_valid), e.vld);
`ifdef FIFO_ERR_FLAGS_EN
    check("ovf_err", int'(ovf_err), e.ovf);
    check("udf_err", int'(udf_err), e.udf);
`endif
  endtask

  // one clock of stimulus: check strobes, push expected, compare after edge
  task automatic step(input bit wr, input bit rd);
    exp_t e;
    @(negedge clk);
    wr_req = wr; rd_req = rd;
    #1;
    lastWe = wr && (mLevel != DEPTH);
    lastRe = rd && (mLevel != 0);
    check("WriteEn", int'(WriteEn), int'(lastWe));
    check("ReadEn", int'(ReadEn), int'(lastRe));
    if (wr && mLevel == DEPTH) mOvf = 1;
    if (rd && mLevel == 0) mUdf = 1;
    mLevel = mLevel + int'(lastWe) - int'(lastRe);
    if (lastWe) mWr = (mWr + 1) % DEPTH;
    if (lastRe) mRd = (mRd + 1) % DEPTH;
    mValid = int'(lastRe);
    e.lvl = mLevel; e.wp = mWr; e.rp = mRd; e.vld = mValid; e.ovf = mOvf; e.udf = mUdf;
    expQ.push_back(e);
    @(posedge clk);
    #1;
    if (expQ.size() == 0) begin
      check("scoreboard_nonempty", 0, 1);
    end else begin
      compareState(expQ.pop_front());
    end
  endtask

  task automatic checkInvariant();
    int diff;
    diff = (int'(wr_ptr) - int'(rd_ptr) + DEPTH) % DEPTH;
    check("ptr_invariant", diff, (int'(level) == DEPTH) ? 0 : int'(level));
  endtask

  vec_t vecs[8];

  initial begin
    // table of constant vectors applied from an empty FIFO
    vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 0};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 1};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 2};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 2};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 0};

    // reset then idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    compareState('{0, 0, 0, 0, 0, 0});
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);

    // 15 consecutive writes
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b1, 1'b0);
      check("fill_level", int'(level), i);
      if (i == 12) check("af_before_13", int'(almost_full), 0);
      if (i == 13) check("af_at_13", int'(almost_full), 1);
    end
    check("full_after_15", int'(full), 1);
    step(1'b1, 1'b0);
    check("blocked_we", int'(lastWe), 0);
    check("wr_ptr_wrapped", int'(wr_ptr), 0);

    // drain 15 reads
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b0, 1'b1);
      check("drain_rd_ptr", int'(rd_ptr), i % DEPTH);
      check("drain_rd_valid", int'(rd_valid), 1);
    end
    check("empty_after_drain", int'(empty), 1);
    step(1'b0, 1'b1);
    check("extra_read_valid", int'(rd_valid), 0);

    // table vectors
    for (int i = 0; i < 8; i++) begin
      step(vecs[i].wr, vecs[i].rd);
      check($sformatf("vec%0d_we", i), int'(lastWe), int'(vecs[i].expWe));
      check($sformatf("vec%0d_re", i), int'(lastRe), int'(vecs[i].expRe));
      check($sformatf("vec%0d_level", i), int'(level), vecs[i].expLevel);
    end

    // simultaneous traffic at level 5
    repeat (5) step(1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1);
      check("sim_level", int'(level), 5);
      checkInvariant();
    end

    // full with both requests: read accepted, write dropped
    repeat (10) step(1'b1, 1'b0);
    check("full_again", int'(full), 1);
    step(1'b1, 1'b1);
    check("full_both_level", int'(level), 14);
    checkInvariant();
    step(1'b1, 1'b0);
    checkInvariant();

    // drain and hit empty with both: write accepted, read dropped
    repeat (DEPTH) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    check("empty_both_level", int'(level), 1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);

    // async reset mid-operation at level 7 with rd_valid high
    repeat (8) step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    check("pre_reset_level", int'(level), 7);
    check("pre_reset_valid", int'(rd_valid), 1);
    @(negedge clk);
    wr_req = 1'b1; rd_req = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    compareState('{0, 0, 0, 0, 0, 0});
    check("reset_we_follows_req", int'(WriteEn), 1);
    check("reset_re_blocked", int'(ReadEn), 0);
    @(posedge clk);
    #1;
    compareState('{0, 0, 0, 0, 0, 0});
    @(negedge clk);
    wr_req = 1'b0; rd_req = 1'b0;
    rst_n = 1'b1;
    #1;
    check("post_reset_wr_ptr", int'(wr_ptr), 0);
    step(1'b1, 1'b0);
    check("first_write_slot", int'(wr_ptr), 1);
    check("first_write_level", int'(level), 1);

    step(1'b0, 1'b0);
    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule

// File: doc/regfile_fifo_ctrl.md
# regfile_fifo_ctrl

Flow-control stage directly upstream of the read and write address counters of the 15-entry register-file FIFO. It accepts producer write requests and consumer read requests and issues the qualified `WriteEn`/`ReadEn` strobes that advance the one-hot ring counters. It keeps shadow binary pointers that always equal the encoded ring-counter addresses, plus occupancy, full/empty flags and a registered read-data-valid strobe for the consumer.

## Interface
- `DEPTH`, 15: FIFO entries; equals ring-counter width; legal range 2..15.
- `AF_LEVEL`, 13: `almost_full` threshold; level >= `AF_LEVEL`.
- `AE_LEVEL`, 2: `almost_empty` threshold; level <= `AE_LEVEL`.
- `clk`  in  1  rising-edge clock for all state.
- `rst_n`  in  1  asynchronous, active-low reset.
- `wr_req`  in  1  producer write request; data on the register-file write port this cycle.
- `rd_req`  in  1  consumer read request.
- `WriteEn`  out  1  write strobe to the write address counter and register file; combinational.
- `ReadEn`  out  1  read strobe to the read address counter; combinational.
- `rd_valid`  out  1  registered; register-file read data valid.
- `wr_ptr`  out  4  shadow write index, 0..DEPTH-1.
- `rd_ptr`  out  4  shadow read index, 0..DEPTH-1.
- `level`  out  4  occupancy, 0..DEPTH.
- `full`, `empty`, `almost_full`, `almost_empty`  out  1 each  registered status flags.
- `ovf_err`, `udf_err`  out  1 each  sticky error flags; present only with `FIFO_ERR_FLAGS_EN`.

## Operation
- `WriteEn = wr_req & ~full`.
- `ReadEn = rd_req & ~empty`.
- No write-through when full. A write with `full=1` is dropped, even if a read is accepted in the same cycle.
- No read-through when empty. A read with `empty=1` is dropped, even if a write is accepted in the same cycle.
- On `WriteEn`: `wr_ptr` goes to `wr_ptr+1`, wrapping `DEPTH-1`→0.
- On `ReadEn`: `rd_ptr` goes to `rd_ptr+1`, wrapping `DEPTH-1`→0.
- Level update:
  - `WriteEn` only: +1.
  - `ReadEn` only: −1.
  - Both or neither: unchanged.
- Level arithmetic uses 4 bits, unsigned. Level never exceeds `DEPTH` and never goes below 0.
- Flags are registered and derived from the next level:
  - `full` = (next level == `DEPTH`).
  - `empty` = (next level == 0).
  - `almost_full` / `almost_empty` use their thresholds.
- Invariant: `wr_ptr − rd_ptr` mod `DEPTH` equals `level`, except when `level == DEPTH`, where the difference is 0.
- `rd_ptr` and `wr_ptr` match the encoder outputs of the ring counters at every cycle. The ring counters reset to slot 0.
- State summary (implicit in `level`): EMPTY (0) → PARTIAL (1..DEPTH−1) → FULL (`DEPTH`). Transitions move one step per cycle at most.

## Timing
- Reset values (async on `rst_n` low):
  - `wr_ptr=0`, `rd_ptr=0`, `level=0`.
  - `empty=1`, `almost_empty=1`.
  - `full=0`, `almost_full=0`, `rd_valid=0`, error flags 0.
  - `WriteEn`/`ReadEn` are 0 while reset is held because `full`/`empty` gate them, except `WriteEn` follows `wr_req` since `full=0`. Counters ignore enables during reset.
- Reset mid-operation discards all contents; the first accepted write after release goes to slot 0.
- Flag latency: one cycle after the enabling edge. Example: the write that fills the FIFO raises `full` at the next edge, and a write in that next cycle is blocked.
- `rd_valid` asserts exactly one cycle after `ReadEn` (matches the register-file synchronous read). Back-to-back reads give back-to-back `rd_valid`.

## Configuration
- `FIFO_ERR_FLAGS_EN` defined:
  - `ovf_err` sets on `wr_req & full`.
  - `udf_err` sets on `rd_req & empty`.
  - Both are sticky until `rst_n` low and become visible one cycle after the offending request.
- Undefined: the ports and logic are absent. Dropped requests are silently ignored.

## Test plan
- Reset then idle: `empty=1`, `level=0`, `wr_ptr=rd_ptr=0`, `ReadEn=0` with `rd_req=1`, `rd_valid` stays 0.
- 15 consecutive writes:
  - `level` counts 1..15.
  - `almost_full` rises after the 13th write.
  - `full=1` after the 15th write.
  - The 16th `wr_req` gives `WriteEn=0` and `wr_ptr` stays 0 (wrapped).
- Drain 15 reads:
  - `rd_valid` follows each `ReadEn` by 1 cycle.
  - `rd_ptr` goes 0..14→0.
  - `empty=1` after the last read.
  - An extra `rd_req` gives `ReadEn=0`.
- Simultaneous `wr_req`/`rd_req` at level 5 for 20 cycles: `level` stays 5, both pointers wrap past 14→0, and the pointer invariant holds.
- Edge cases:
  - `full` with `wr_req`+`rd_req`: read accepted, write dropped, `level`→14.
  - `empty` with both: write accepted, read dropped, `level`→1.
  - With `FIFO_ERR_FLAGS_EN`, `ovf_err`/`udf_err` set and remain set.
- Assert `rst_n` low at `level=7` mid-burst: all outputs return to reset values asynchronously, and after release a write lands at `wr_ptr=0`.
